// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg: shared encodings for the multiply/divide unit.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_datapath.sv
// ---------------------------------------------------------------------------
// mdu_datapath: operand latch, shift-add / restoring-divide step, sign fix-up.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [2*WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0]   opnd_q,     opnd_d;
  logic [WIDTH-1:0]   raw_a_q,    raw_a_d;
  logic [1:0]         op_q,       op_d;
  logic               sign_a_q,   sign_a_d;
  logic               sign_b_q,   sign_b_d;
  logic               div_zero_q, div_zero_d;

  logic               w_ld_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_rem;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;

  logic               w_signed;
  logic               w_is_div;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_ld_signed = ~op_i[0];
  assign w_mag_a     = (w_ld_signed && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign w_mag_b     = (w_ld_signed && opb_i[WIDTH-1]) ? -opb_i : opb_i;

  // Multiply keeps the multiplier in acc low half and adds the multiplicand;
  // divide keeps the dividend in acc low half and subtracts the divisor.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign w_div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_rem - {1'b0, opnd_q};
  assign w_div_ge   = ~w_div_diff[WIDTH];

  always_comb begin
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    raw_a_d    = raw_a_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    if (load_i) begin
      op_d       = op_i;
      raw_a_d    = opa_i;
      sign_a_d   = w_ld_signed & opa_i[WIDTH-1];
      sign_b_d   = w_ld_signed & opb_i[WIDTH-1];
      div_zero_d = (opb_i == '0);
      opnd_d     = op_i[1] ? w_mag_b : w_mag_a;
      acc_d      = {{WIDTH{1'b0}}, (op_i[1] ? w_mag_a : w_mag_b)};
    end else if (step_i) begin
      if (op_q[1]) begin
        acc_d = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rem[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], w_div_ge};
      end else begin
        acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      raw_a_q    <= '0;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      raw_a_q    <= raw_a_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Remainder follows the dividend sign; quotient/product follow sign XOR.
  assign w_signed = ~op_q[0];
  assign w_is_div = op_q[1];
  assign w_prod   = (w_signed && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
  assign w_quot   = (w_signed && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0]
                                                        : acc_q[WIDTH-1:0];
  assign w_rem    = (w_signed && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                           : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi_o = w_prod[2*WIDTH-1:WIDTH];
    res_lo_o = w_prod[WIDTH-1:0];
    if (w_is_div) begin
      if (div_zero_q) begin
        res_hi_o = raw_a_q;
        res_lo_o = {WIDTH{1'b1}};
      end else begin
        res_hi_o = w_rem;
        res_lo_o = w_quot;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] HiLoWrData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             w_ready;
  logic             w_launch;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_ready  = (state_q == IDLE) || (state_q == DONE);
  assign w_launch = w_ready && Start;

  mdu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk_i    (Clk),
    .rst_ni   (Rst_n),
    .load_i   (w_launch),
    .step_i   (state_q == CALC),
    .op_i     (Op),
    .opa_i    (OpA),
    .opb_i    (OpB),
    .res_hi_o (w_res_hi),
    .res_lo_o (w_res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE, DONE: state_d = Start ? CALC : IDLE;
      CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // MTHI/MTLO are honoured only when idle; FIX overwrites both registers.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == FIX) begin
      hi_d = w_res_hi;
      lo_d = w_res_lo;
    end else if (w_ready) begin
      if (HiWrite) hi_d = HiLoWrData;
      if (LoWrite) lo_d = HiLoWrData;
    end
  end

  assign busy_d = (state_d == CALC) || (state_d == FIX);
  assign done_d = (state_d == DONE);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_div_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] HiLoWrData;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_assert = 0;
  int n_fail   = 0;
  int edges    = 0;
  int busy_cnt = 0;
  bit disturb  = 1'b0;

  always #5 Clk = ~Clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Op         (Op),
    .OpA        (OpA),
    .OpB        (OpB),
    .HiWrite    (HiWrite),
    .LoWrite    (LoWrite),
    .HiLoWrData (HiLoWrData),
    .Busy       (Busy),
    .Done       (Done),
    .Hi         (Hi),
    .Lo         (Lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; Start is sampled at the next posedge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; OpA = a; OpB = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    OpA = 32'h5A5A_5A5A; OpB = 32'h0000_0003; Op = 2'b00;
    busy_cnt = Busy ? 1 : 0;
  endtask

  task automatic wait_done();
    edges = 0;
    while (!Done && edges < 40) begin
      @(negedge Clk);
      edges++;
      if (Busy) busy_cnt++;
      if (disturb) begin
        if (edges == 5) begin
          Start = 1'b1; Op = 2'b11; OpA = 32'd77; OpB = 32'd5;
        end
        if (edges == 6)  Start = 1'b0;
        if (edges == 10) begin HiWrite = 1'b1; HiLoWrData = 32'h1234_5678; end
        if (edges == 11) HiWrite = 1'b0;
      end
    end
    chk("done_seen", {31'b0, Done}, 32'd1);
  endtask

  initial begin
    Rst_n = 1'b0; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; HiLoWrData = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_hi",   Hi, 32'd0);
    chk("rst_lo",   Lo, 32'd0);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    chk("multu_latency", edges, 32'd33);
    chk("multu_busy_cycles", busy_cnt, 32'd33);
    chk("multu_busy_in_done", {31'b0, Busy}, 32'd0);
    chk("multu_hi", Hi, 32'hFFFF_FFFE);
    chk("multu_lo", Lo, 32'h0000_0001);

    launch(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done();
    chk("b2b_latency", edges, 32'd33);
    chk("mult_hi", Hi, 32'hFFFF_FFFF);
    chk("mult_lo", Lo, 32'hFFFF_FFF1);
    @(negedge Clk);
    chk("done_pulse_width", {31'b0, Done}, 32'd0);
    chk("mult_hi_hold", Hi, 32'hFFFF_FFFF);

    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    chk("div_neg_lo", Lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", Hi, 32'hFFFF_FFFF);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    chk("div_ovf_lo", Lo, 32'h8000_0000);
    chk("div_ovf_hi", Hi, 32'h0000_0000);

    launch(2'b11, 32'd100, 32'd0);
    wait_done();
    chk("divu_zero_latency", edges, 32'd33);
    chk("divu_zero_lo", Lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", Hi, 32'h0000_0064);

    launch(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done();
    chk("div_negb_lo", Lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", Hi, 32'h0000_0001);

    launch(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done();
    chk("mult_min_hi", Hi, 32'h4000_0000);
    chk("mult_min_lo", Lo, 32'h0000_0000);

    disturb = 1'b1;
    launch(2'b01, 32'h0001_0000, 32'h0001_0000);
    wait_done();
    disturb = 1'b0;
    chk("disturb_latency", edges, 32'd33);
    chk("disturb_hi", Hi, 32'h0000_0001);
    chk("disturb_lo", Lo, 32'h0000_0000);

    @(negedge Clk);
    HiWrite = 1'b1; HiLoWrData = 32'h1234_5678;
    @(negedge Clk);
    HiWrite = 1'b0;
    chk("mthi_idle_hi", Hi, 32'h1234_5678);
    chk("mthi_idle_lo", Lo, 32'h0000_0000);

    HiWrite = 1'b1; LoWrite = 1'b1; HiLoWrData = 32'hCAFE_F00D;
    @(negedge Clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    chk("mthilo_hi", Hi, 32'hCAFE_F00D);
    chk("mthilo_lo", Lo, 32'hCAFE_F00D);

    launch(2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge Clk);
    chk("pre_rst_busy", {31'b0, Busy}, 32'd1);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("midrst_busy", {31'b0, Busy}, 32'd0);
    chk("midrst_done", {31'b0, Done}, 32'd0);
    chk("midrst_hi", Hi, 32'd0);
    chk("midrst_lo", Lo, 32'd0);
    @(negedge Clk);
    chk("midrst_idle", {31'b0, Busy}, 32'd0);

    launch(2'b11, 32'd1000, 32'd7);
    wait_done();
    chk("post_rst_latency", edges, 32'd33);
    chk("post_rst_lo", Lo, 32'd142);
    chk("post_rst_hi", Hi, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
